// File: rtl/seq_div16_pkg.sv
// ==================================================================
// seq_div16_pkg : shared widths and FSM state encoding for seq_div16
// Rev 1.0
// ==================================================================
`default_nettype none

package seq_div16_pkg;

   localparam int DIV_DW = 16;
   localparam int DIV_VW = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_div16_if.sv
// ==================================================================
// seq_div16_if : request/result bundle between operand source and divider
// Rev 1.0
// ==================================================================
`default_nettype none

interface seq_div16_if #(
   parameter int DW = 16,
   parameter int VW = 8
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quot;
   logic [VW-1:0] rem;
   logic          div_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quot, rem, div_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quot, rem, div_zero
   );
endinterface

`default_nettype wire

// File: rtl/seq_div16_div_step.sv
// ==================================================================
// div_step : one combinational restoring-division step
// Rev 1.0
// ==================================================================
`default_nettype none

module div_step
   import seq_div16_pkg::*;
#(
   parameter int VW = DIV_VW
) (
   input  logic [VW:0]   prem,
   input  logic          din,
   input  logic [VW-1:0] dsr,
   output logic [VW:0]   prem_next,
   output logic          qbit
);

   // prem < dsr is invariant, so the top bit of the shifted value is always 0;
   // carrying it keeps the compare width-safe without any overflow case.
   logic [VW+1:0] shifted;

   assign shifted   = {prem, din};
   assign qbit      = (shifted >= {2'b00, dsr});
   assign prem_next = qbit ? (VW+1)'(shifted - {2'b00, dsr}) : (VW+1)'(shifted);

endmodule

`default_nettype wire

// File: rtl/seq_div16.sv
// ==================================================================
// seq_div16 : sequential 16/8 unsigned restoring divider, 1 quotient bit/clk
// Rev 1.0
// ==================================================================
`default_nettype none

module seq_div16
   import seq_div16_pkg::*;
#(
   parameter int DW = DIV_DW,
   parameter int VW = DIV_VW
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_div16_if.slave bus
);

   localparam int CW = $clog2(DW);

   state_t        state;
   state_t        state_next;
   logic          accept;
   logic          last_step;
   logic          qbit;
   logic [VW:0]   prem;
   logic [VW:0]   prem_next;
   logic [DW-1:0] dvd;
   logic [VW-1:0] dsr;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last_step  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = (bus.divisor == '0) ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt == CW'(DW - 1)) begin
               last_step  = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = (bus.divisor == '0) ? S_DONE : S_BUSY;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign bus.busy = (state == S_BUSY);
   assign bus.done = (state == S_DONE);

   div_step #(
      .VW (VW)
   ) u_step (
      .prem      (prem),
      .din       (dvd[DW-1]),
      .dsr       (dsr),
      .prem_next (prem_next),
      .qbit      (qbit)
   );

   // Quotient bits shift into the vacated LSBs of the dividend register,
   // so after DW steps it holds the full quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd          <= '0;
         dsr          <= '0;
         prem         <= '0;
         cnt          <= '0;
         bus.quot     <= '0;
         bus.rem      <= '0;
         bus.div_zero <= 1'b0;
      end else if (accept) begin
         dvd          <= bus.dividend;
         dsr          <= bus.divisor;
         prem         <= '0;
         cnt          <= '0;
         bus.div_zero <= (bus.divisor == '0);
         if (bus.divisor == '0) begin
            bus.quot <= '1;
            bus.rem  <= bus.dividend[VW-1:0];
         end
      end else if (state == S_BUSY) begin
         prem <= prem_next;
         dvd  <= {dvd[DW-2:0], qbit};
         cnt  <= cnt + 1'b1;
         if (last_step) begin
            bus.quot <= {dvd[DW-2:0], qbit};
            bus.rem  <= prem_next[VW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_div16.sv
// ==================================================================
// tb_seq_div16 : directed and swept self-checking bench for seq_div16
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_seq_div16;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   seq_div16_if #(.DW(16), .VW(8)) bus ();

   seq_div16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present a request for one cycle; returns at the negedge after acceptance.
   task automatic launch(input logic [15:0] n, input logic [7:0] d);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = n;
      bus.divisor  = d;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = 16'hA5A5;
      bus.divisor  = 8'h5A;
   endtask

   task automatic wait_done(output int lat, output int busy_n);
      lat    = 1;
      busy_n = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) busy_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int          lat;
      int          busy_n;
      logic        saw_done;
      logic [15:0] n;
      logic [7:0]  d;
      logic [15:0] eq;
      logic [7:0]  er;

      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quot", 32'(bus.quot), 32'd0);
      check("rst_rem",  32'(bus.rem),  32'd0);
      check("rst_dz",   32'(bus.div_zero), 32'd0);
      rst_n = 1'b1;

      // 1: max / max
      launch(16'd65535, 8'd255);
      wait_done(lat, busy_n);
      check("t1_lat",  32'(lat), 32'd17);
      check("t1_quot", 32'(bus.quot), 32'd257);
      check("t1_rem",  32'(bus.rem),  32'd0);
      check("t1_dz",   32'(bus.div_zero), 32'd0);

      // 2: 1000 / 7, busy and done widths
      launch(16'd1000, 8'd7);
      wait_done(lat, busy_n);
      check("t2_busy_n", 32'(busy_n), 32'd16);
      check("t2_quot",   32'(bus.quot), 32'd142);
      check("t2_rem",    32'(bus.rem),  32'd6);
      @(negedge clk);
      check("t2_done_1cyc", 32'(bus.done), 32'd0);
      check("t2_hold_quot", 32'(bus.quot), 32'd142);

      // 3: divide by zero, then clearing DIV_ZERO
      launch(16'h3039, 8'd0);
      wait_done(lat, busy_n);
      check("t3_lat",  32'(lat), 32'd1);
      check("t3_quot", 32'(bus.quot), 32'hFFFF);
      check("t3_rem",  32'(bus.rem),  32'h39);
      check("t3_dz",   32'(bus.div_zero), 32'd1);
      launch(16'd10, 8'd3);
      check("t3_dz_clr", 32'(bus.div_zero), 32'd0);
      wait_done(lat, busy_n);
      check("t3b_quot", 32'(bus.quot), 32'd3);
      check("t3b_rem",  32'(bus.rem),  32'd1);

      // 4: small dividend and unit divisor
      launch(16'd5, 8'd9);
      wait_done(lat, busy_n);
      check("t4a_quot", 32'(bus.quot), 32'd0);
      check("t4a_rem",  32'(bus.rem),  32'd5);
      launch(16'd40000, 8'd1);
      wait_done(lat, busy_n);
      check("t4b_quot", 32'(bus.quot), 32'd40000);
      check("t4b_rem",  32'(bus.rem),  32'd0);

      // 5: START while busy ignored; START in DONE accepted back-to-back
      launch(16'd500, 8'd4);
      repeat (4) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd9;
      bus.divisor  = 8'd9;
      @(negedge clk);
      bus.start    = 1'b0;
      wait_done(lat, busy_n);
      check("t5a_lat",  32'(lat), 32'd12);
      check("t5a_quot", 32'(bus.quot), 32'd125);
      check("t5a_rem",  32'(bus.rem),  32'd0);
      bus.start    = 1'b1;
      bus.dividend = 16'd9;
      bus.divisor  = 8'd9;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = 16'd0;
      bus.divisor  = 8'd0;
      check("t5b_busy", 32'(bus.busy), 32'd1);
      wait_done(lat, busy_n);
      check("t5b_lat",  32'(lat), 32'd17);
      check("t5b_quot", 32'(bus.quot), 32'd1);
      check("t5b_rem",  32'(bus.rem),  32'd0);

      // 6: asynchronous reset in the middle of an operation
      launch(16'd1000, 8'd7);
      repeat (7) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_busy", 32'(bus.busy), 32'd0);
      check("t6_done", 32'(bus.done), 32'd0);
      check("t6_quot", 32'(bus.quot), 32'd0);
      check("t6_rem",  32'(bus.rem),  32'd0);
      check("t6_dz",   32'(bus.div_zero), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      saw_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      check("t6_no_done", 32'(saw_done), 32'd0);
      launch(16'd1000, 8'd7);
      wait_done(lat, busy_n);
      check("t6b_lat",  32'(lat), 32'd17);
      check("t6b_quot", 32'(bus.quot), 32'd142);
      check("t6b_rem",  32'(bus.rem),  32'd6);

      // Random sweep against a reference quotient/remainder
      for (int i = 0; i < 2000; i++) begin
         n = 16'($urandom);
         d = 8'($urandom_range(0, 255));
         launch(n, d);
         wait_done(lat, busy_n);
         if (d == 8'd0) begin
            eq = 16'hFFFF;
            er = n[7:0];
         end else begin
            eq = n / 16'(d);
            er = 8'(n % 16'(d));
         end
         check("rnd_quot", 32'(bus.quot), 32'(eq));
         check("rnd_rem",  32'(bus.rem),  32'(er));
         check("rnd_dz",   32'(bus.div_zero), 32'(d == 8'd0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
